radix_serial_adder: RTL
=======================

// Module: radix_serial_adder
// PURPOSE
//  Digit-serial adder for two NDIG-digit radix-RADIX operands. Each digit is packed in DW bits, least-significant digit (LSD) at bit 0.
//  Processes one digit pair per clock, LSD first, with a registered carry.
//  Successor to the single-digit base-5 combinational adder; generalises radix and digit count and adds a start/done handshake.
//  Sits in the arithmetic datapath wherever multi-digit base-N sums are needed at low area.
// PARAMETERS
//  RADIX  5  digit base, 2..2**DW
//  DW     3  bits per digit, >= clog2(RADIX)
//  NDIG   4  digits per operand, >= 1
// PORTS
//  clk    in   1        rising-edge clock
//  rst    in   1        asynchronous, active-high reset
//  start  in   1        request; sampled only while ready=1
//  a      in   NDIG*DW  operand A, digit i at [i*DW +: DW]
//  b      in   NDIG*DW  operand B, same packing
//  ready  out  1        high in IDLE
//  busy   out  1        high in RUN
//  done   out  1        one-cycle pulse, result valid
//  sum    out  NDIG*DW  result digits, same packing; held until next accepted start
//  cout   out  1        carry out of the most-significant digit; held with sum
//  err    out  1        invalid-digit flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, err=0, carry=0, idx=0.
//  States: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start=1 at an edge latches a and b into shift registers, clears carry, idx and err, and moves to RUN.
//   RUN: each edge processes digit idx:
//    s = ad + bd + carry, computed at DW+1 bits.
//    If s >= RADIX: digit = (s-RADIX)[DW-1:0], carry <= 1. Otherwise digit = s[DW-1:0], carry <= 0.
//    Only one subtraction of RADIX is ever applied.
//    digit is shifted into sum from the MSD end; idx increments.
//    After the edge with idx = NDIG-1, the FSM moves to DONE and cout <= the final carry.
//   DONE: done=1 for exactly one cycle, then IDLE.
//  Latency: start sampled at edge k -> done high in the cycle after edge k+NDIG, i.e. NDIG+1 cycles. Throughput is one add per NDIG+2 cycles.
//  sum and cout change only during RUN. In IDLE they hold the last result.
//  start while busy=1 or done=1 is ignored; it is not queued.
//  start in the same cycle as done is ignored; the next one is accepted in IDLE.
//  a and b may change freely after acceptance.
//  rst asserted mid-RUN aborts immediately to reset values; no done pulse is produced.
//  Operand digits >= RADIX are not rejected; they follow the arithmetic rule above.
// CONFIGURATION
//  DIGIT_CHECK_EN defined:
//   - At acceptance, if any digit of a or b is >= RADIX, err <= 1.
//   - err stays high until the next accepted start or rst.
//   - The add still runs and produces sum by the arithmetic rule.
//  DIGIT_CHECK_EN undefined:
//   - err is tied to 0; no compare logic is built.
// TESTING (RADIX=5, DW=3, NDIG=4; digits written MSD..LSD)
//  1. a=0004, b=0001, start for 1 cycle
//     -> busy for 4 cycles, then done pulse; sum=0010, cout=0.
//  2. a=4444, b=0001 (full carry ripple)
//     -> sum=0000, cout=1; done exactly 5 cycles after the start edge.
//  3. start held high through RUN and DONE with new operands
//     -> only the first request computes; second add accepted in IDLE; done pulses once per accepted start.
//  4. rst at the 2nd RUN cycle of a=1234, b=4321
//     -> immediate ready=1, sum=0, cout=0, no done.
//     Then start a=1234, b=4321 -> sum=1110, cout=1.
//  5. DIGIT_CHECK_EN defined, a=0007, b=0005
//     -> err=1 at acceptance; LSD s=12 -> digit 7, carry 1; sum=0017, cout=0.
//     Undefined: same sum, err=0.
//  6. Back-to-back: start accepted in IDLE right after done
//     -> second result correct, first result held until the second add's RUN begins.

Source files
------------

// File: rtl/radix_serial_adder.sv
// Digit-serial radix-RADIX adder, one digit pair per clock, LSD first, start/done handshake.
// Optional macro DIGIT_CHECK_EN: flag operand digits >= RADIX on err at acceptance.
module radix_serial_adder #(
  parameter int RADIX = 5,
  parameter int DW    = 3,
  parameter int NDIG  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NDIG*DW-1:0] a,
  input  logic [NDIG*DW-1:0] b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [NDIG*DW-1:0] sum,
  output logic               cout,
  output logic               err
);
  localparam int W  = NDIG * DW;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [DW:0]   RADIX_V = (DW+1)'(RADIX);
  localparam logic [IW-1:0] LAST    = IW'(NDIG - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic          carry_q, carry_d, cout_q, cout_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DW:0]   s_raw, s_adj;
  logic [DW-1:0] digit;
  logic          carry_nx;

  // Single conditional subtraction; out-of-range digits simply follow this rule.
  always_comb begin
    s_raw    = {1'b0, a_q[DW-1:0]} + {1'b0, b_q[DW-1:0]} + {{DW{1'b0}}, carry_q};
    carry_nx = (s_raw >= RADIX_V);
    s_adj    = carry_nx ? (s_raw - RADIX_V) : s_raw;
    digit    = s_adj[DW-1:0];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d             = a_q >> DW;
        b_d             = b_q >> DW;
        sum_d           = sum_q >> DW;
        sum_d[W-1 -: DW] = digit;
        carry_d         = carry_nx;
        idx_d           = idx_q + IW'(1);
        if (idx_q == LAST) begin
          cout_d  = carry_nx;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign busy  = (state_q == S_RUN);
  assign done  = (state_q == S_DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;

`ifdef DIGIT_CHECK_EN
  logic bad_digit;
  logic err_q;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if ({1'b0, a[i*DW +: DW]} >= RADIX_V || {1'b0, b[i*DW +: DW]} >= RADIX_V)
        bad_digit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (state_q == S_IDLE && start)
      err_q <= bad_digit;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
